// File: rtl/executor_comando.sv
// executor_comando
// Validates decoded command frames (comando / comparador pair) and executes the
// accepted ones. A frame is accepted when comparador is the exact bitwise
// complement of comando, and rejected otherwise.
// Accepted frames do the following:
//   - update codigo,
//   - adjust nivel on CMD_MAIS / CMD_MENOS,
//   - retrigger a hold window of TIMEOUT cycles that drives led,
//   - flag repetido when the same code comes back while that window is open.
// Rejected frames bump a saturating error counter.
//
// Ports
//   clk        : single clock, posedge
//   reset      : synchronous, active-high
//   novo       : one-cycle strobe, comando/comparador hold a fresh frame
//   comando    : decoded command byte
//   comparador : decoded inverted-command byte
//   codigo     : last accepted command
//   valido     : one-cycle pulse when a frame is accepted
//   erro       : one-cycle pulse when a frame is rejected
//   cont_erro  : rejected-frame count, saturates at 15
//   nivel      : level, +1 on CMD_MAIS, -1 on CMD_MENOS, saturating 0..15
//   repetido   : last accepted code repeated inside the hold window
//   led        : high while the hold window runs
//   seg_alto   : active-low segments (bit0=a .. bit6=g) for codigo[7:4]
//   seg_baixo  : active-low segments (bit0=a .. bit6=g) for codigo[3:0]
//
// Handshake: novo is a plain strobe with no back-pressure. It is only honoured
// in OCIOSO. A strobe seen in any other state is dropped, not queued. Result
// pulses (valido/erro) come out registered: novo sampled at edge N gives a
// pulse during the cycle after edge N+2, together with the new codigo.
module executor_comando #(
  parameter int unsigned TIMEOUT   = 5000000,
  parameter logic [7:0]  CMD_MAIS  = 8'h18,
  parameter logic [7:0]  CMD_MENOS = 8'h52
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       novo,
  input  logic [7:0] comando,
  input  logic [7:0] comparador,
  output logic [7:0] codigo,
  output logic       valido,
  output logic       erro,
  output logic [3:0] cont_erro,
  output logic [3:0] nivel,
  output logic       repetido,
  output logic       led,
  output logic [6:0] seg_alto,
  output logic [6:0] seg_baixo
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CHECA   = 2'd1,
    EXECUTA = 2'd2,
    REJEITA = 2'd3
  } estado_t;

  estado_t         estado_q, estado_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      cmp_q, cmp_d;
  logic [7:0]      codigo_q, codigo_d;
  logic            valido_q, valido_d;
  logic            erro_q, erro_d;
  logic [3:0]      cont_erro_q, cont_erro_d;
  logic [3:0]      nivel_q, nivel_d;
  logic            repetido_q, repetido_d;
  logic [TW-1:0]   timer_q, timer_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      cmd_q       <= 8'h00;
      cmp_q       <= 8'h00;
      codigo_q    <= 8'h00;
      valido_q    <= 1'b0;
      erro_q      <= 1'b0;
      cont_erro_q <= 4'd0;
      nivel_q     <= 4'd0;
      repetido_q  <= 1'b0;
      timer_q     <= '0;
    end else begin
      estado_q    <= estado_d;
      cmd_q       <= cmd_d;
      cmp_q       <= cmp_d;
      codigo_q    <= codigo_d;
      valido_q    <= valido_d;
      erro_q      <= erro_d;
      cont_erro_q <= cont_erro_d;
      nivel_q     <= nivel_d;
      repetido_q  <= repetido_d;
      timer_q     <= timer_d;
    end
  end

  always_comb begin
    estado_d    = estado_q;
    cmd_d       = cmd_q;
    cmp_d       = cmp_q;
    codigo_d    = codigo_q;
    valido_d    = 1'b0;
    erro_d      = 1'b0;
    cont_erro_d = cont_erro_q;
    nivel_d     = nivel_q;
    repetido_d  = repetido_q;
    timer_d     = timer_q;

    // Free-running hold window. When it expires, the repeat flag drops
    // together with led. EXECUTA below overrides both when it reloads.
    if (timer_q != '0) begin
      timer_d = timer_q - TW'(1);
      if (timer_q == TW'(1)) begin
        repetido_d = 1'b0;
      end
    end

    case (estado_q)
      OCIOSO: begin
        if (novo) begin
          cmd_d    = comando;
          cmp_d    = comparador;
          estado_d = CHECA;
        end
      end
      CHECA: begin
        estado_d = (cmp_q == ~cmd_q) ? EXECUTA : REJEITA;
      end
      EXECUTA: begin
        codigo_d = cmd_q;
        valido_d = 1'b1;
        if (cmd_q == CMD_MAIS && nivel_q != 4'd15) begin
          nivel_d = nivel_q + 4'd1;
        end else if (cmd_q == CMD_MENOS && nivel_q != 4'd0) begin
          nivel_d = nivel_q - 4'd1;
        end
        // Repeat is judged against the timer value on entry, before reload.
        repetido_d = (cmd_q == codigo_q) && (timer_q != '0);
        timer_d    = TW'(TIMEOUT);
        estado_d   = OCIOSO;
      end
      REJEITA: begin
        erro_d = 1'b1;
        if (cont_erro_q != 4'd15) begin
          cont_erro_d = cont_erro_q + 4'd1;
        end
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    s = 7'b1111111;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign codigo    = codigo_q;
  assign valido    = valido_q;
  assign erro      = erro_q;
  assign cont_erro = cont_erro_q;
  assign nivel     = nivel_q;
  assign repetido  = repetido_q;
  assign led       = (timer_q != '0);
  assign seg_alto  = hex7(codigo_q[7:4]);
  assign seg_baixo = hex7(codigo_q[3:0]);

endmodule

// File: tb/tb_executor_comando.sv
// tb_executor_comando
// Bench for executor_comando with TIMEOUT=100. Expected result words are pushed
// into exp_q when a frame is driven and popped when valido/erro appears.
module tb_executor_comando;

  localparam int         TIMEOUT_TB = 100;
  localparam logic [7:0] MAIS       = 8'h18;
  localparam logic [7:0] MENOS      = 8'h52;
  localparam int         EW         = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       novo = 1'b0;
  logic [7:0] comando = 8'h00;
  logic [7:0] comparador = 8'h00;
  logic [7:0] codigo;
  logic       valido;
  logic       erro;
  logic [3:0] cont_erro;
  logic [3:0] nivel;
  logic       repetido;
  logic       led;
  logic [6:0] seg_alto;
  logic [6:0] seg_baixo;

  executor_comando #(
    .TIMEOUT  (TIMEOUT_TB),
    .CMD_MAIS (MAIS),
    .CMD_MENOS(MENOS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .novo      (novo),
    .comando   (comando),
    .comparador(comparador),
    .codigo    (codigo),
    .valido    (valido),
    .erro      (erro),
    .cont_erro (cont_erro),
    .nivel     (nivel),
    .repetido  (repetido),
    .led       (led),
    .seg_alto  (seg_alto),
    .seg_baixo (seg_baixo)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard / model state ----------------
  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass = 0;

  logic [7:0] m_codigo;
  logic [3:0] m_nivel;
  logic [3:0] m_cont;
  logic       m_rep;
  int         m_last_ok;

  logic [6:0] glyph_tab [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic model_reset();
    m_codigo  = 8'h00;
    m_nivel   = 4'd0;
    m_cont    = 4'd0;
    m_rep     = 1'b0;
    m_last_ok = -1000000;
  endtask

  // Called at the negedge where novo is raised. The sampling edge is cyc+1
  // and the result becomes visible after edge cyc+3.
  task automatic push_expect(input logic [7:0] cmd, input logic [7:0] cmp);
    logic ok;
    logic led_e;
    int   out_edge;
    ok       = (cmp == ~cmd);
    out_edge = cyc + 3;
    if (ok) begin
      m_rep = (cmd == m_codigo) && (out_edge - m_last_ok <= TIMEOUT_TB);
      m_codigo = cmd;
      if (cmd == MAIS && m_nivel != 4'd15) m_nivel = m_nivel + 4'd1;
      else if (cmd == MENOS && m_nivel != 4'd0) m_nivel = m_nivel - 4'd1;
      m_last_ok = out_edge;
      led_e = 1'b1;
    end else begin
      if (m_cont != 4'd15) m_cont = m_cont + 4'd1;
      led_e = (out_edge - m_last_ok < TIMEOUT_TB);
      if (!led_e) m_rep = 1'b0;
    end
    exp_q.push_back({ok, ~ok, m_codigo, m_nivel, m_cont, m_rep, led_e});
  endtask

  // ---------------- driver ----------------
  // Returns at the negedge where the result pulse is visible, so a following
  // call drives the next frame at the earliest accepted slot.
  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] cmp);
    logic [EW-1:0] exp_w;
    logic [EW-1:0] got_w;
    int            waited;
    logic          seen;
    push_expect(cmd, cmp);
    novo = 1'b1;
    comando = cmd;
    comparador = cmp;
    @(negedge clk);
    novo = 1'b0;
    comando = 8'($urandom);
    comparador = 8'($urandom);
    n_checks++;
    if (valido !== 1'b0 || erro !== 1'b0)
      $display("FAIL pulse_width: valido=%b erro=%b want 0 0", valido, erro);
    else n_pass++;
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 5) begin
      @(negedge clk);
      waited++;
      if (valido === 1'b1 || erro === 1'b1) seen = 1'b1;
    end
    exp_w = exp_q.pop_front();
    n_checks++;
    if (!seen || waited != 2)
      $display("FAIL latency: seen=%b after %0d cycles, want 2", seen, waited);
    else n_pass++;
    got_w = {valido, erro, codigo, nivel, cont_erro, repetido, led};
    n_checks++;
    if (got_w !== exp_w)
      $display("FAIL result cmd=%h cmp=%h: got v/e/cod/niv/cnt/rep/led=%h want %h",
               cmd, cmp, got_w, exp_w);
    else n_pass++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    novo = 1'b1;
    comando = 8'h77;
    comparador = 8'h88;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    novo = 1'b0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({codigo, valido, erro, cont_erro, nivel, repetido, led} !== 19'd0)
      $display("FAIL reset_outputs: got %h want 0",
               {codigo, valido, erro, cont_erro, nivel, repetido, led});
    else n_pass++;
    n_checks++;
    if (seg_alto !== 7'b1000000 || seg_baixo !== 7'b1000000)
      $display("FAIL reset_segs: got %b %b want 1000000 1000000", seg_alto, seg_baixo);
    else n_pass++;
  endtask

  task automatic test_valid_frame();
    send_frame(8'h45, 8'hBA);
    n_checks++;
    if (seg_alto !== 7'b0011001 || seg_baixo !== 7'b0010010)
      $display("FAIL segs_45: got %b %b want 0011001 0010010", seg_alto, seg_baixo);
    else n_pass++;
  endtask

  task automatic test_bad_frame();
    for (int i = 0; i < 20; i++) send_frame(8'h45, 8'hBB);
    n_checks++;
    if (cont_erro !== 4'd15 || codigo !== 8'h45)
      $display("FAIL cont_sat: got cont=%0d cod=%h want 15 45", cont_erro, codigo);
    else n_pass++;
  endtask

  task automatic test_level();
    do_reset();
    for (int i = 0; i < 17; i++) send_frame(MAIS, ~MAIS);
    n_checks++;
    if (nivel !== 4'd15) $display("FAIL nivel_top: got %0d want 15", nivel);
    else n_pass++;
    for (int i = 0; i < 17; i++) send_frame(MENOS, ~MENOS);
    n_checks++;
    if (nivel !== 4'd0) $display("FAIL nivel_bottom: got %0d want 0", nivel);
    else n_pass++;
  endtask

  task automatic test_random_codes();
    logic [7:0] cmd;
    logic [7:0] cmp;
    for (int i = 0; i < 16; i++) begin
      cmd = 8'($urandom_range(0, 255));
      cmp = ~cmd;
      if ($urandom_range(0, 3) == 0) cmp = cmp ^ (8'h01 << $urandom_range(0, 7));
      send_frame(cmd, cmp);
      n_checks++;
      if (seg_alto !== glyph_tab[m_codigo[7:4]] || seg_baixo !== glyph_tab[m_codigo[3:0]])
        $display("FAIL segs_%h: got %b %b want %b %b", m_codigo, seg_alto, seg_baixo,
                 glyph_tab[m_codigo[7:4]], glyph_tab[m_codigo[3:0]]);
      else n_pass++;
    end
  endtask

  task automatic test_repeat_timeout();
    int e2;
    int guard;
    do_reset();
    send_frame(8'h45, 8'hBA);
    repeat (47) @(negedge clk);
    send_frame(8'h45, 8'hBA);
    e2 = cyc;
    guard = 0;
    while (cyc < e2 + 99 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (led !== 1'b1 || repetido !== 1'b1)
      $display("FAIL hold_99: got led=%b rep=%b want 1 1", led, repetido);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (led !== 1'b0 || repetido !== 1'b0)
      $display("FAIL hold_100: got led=%b rep=%b want 0 0", led, repetido);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int            n_val;
    logic [EW-1:0] exp_w;
    do_reset();
    push_expect(8'h33, 8'hCC);
    novo = 1'b1; comando = 8'h33; comparador = 8'hCC;
    @(negedge clk);
    comando = MAIS; comparador = ~MAIS;
    @(negedge clk);
    comando = MENOS; comparador = ~MENOS;
    @(negedge clk);
    novo = 1'b0;
    n_val = 0;
    for (int i = 0; i < 8; i++) begin
      if (valido === 1'b1) begin
        n_val++;
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          n_checks++;
          if ({valido, erro, codigo, nivel, cont_erro, repetido, led} !== exp_w)
            $display("FAIL b2b_result: got %h want %h",
                     {valido, erro, codigo, nivel, cont_erro, repetido, led}, exp_w);
          else n_pass++;
        end
      end
      if (erro === 1'b1) n_val++;
      @(negedge clk);
    end
    n_checks++;
    if (n_val != 1) $display("FAIL b2b_count: got %0d pulses want 1", n_val);
    else n_pass++;
  endtask

  task automatic test_reset_in_checa();
    int n_pulse;
    do_reset();
    send_frame(MAIS, ~MAIS);
    send_frame(8'h45, 8'hBB);
    novo = 1'b1; comando = 8'h45; comparador = 8'hBA;
    @(negedge clk);
    novo = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    n_checks++;
    if ({codigo, valido, erro, cont_erro, nivel, repetido, led} !== 19'd0)
      $display("FAIL checa_reset: got %h want 0",
               {codigo, valido, erro, cont_erro, nivel, repetido, led});
    else n_pass++;
    n_pulse = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (valido === 1'b1 || erro === 1'b1) n_pulse++;
    end
    n_checks++;
    if (n_pulse != 0) $display("FAIL checa_discard: got %0d pulses want 0", n_pulse);
    else n_pass++;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    model_reset();
    test_reset();
    test_valid_frame();
    test_bad_frame();
    test_level();
    test_random_codes();
    test_repeat_timeout();
    test_back_to_back();
    test_reset_in_checa();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL queue_drain: got %0d left want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/executor_comando.md
EXECUTOR_COMANDO -- requirements
Module: executor_comando

Interface
REQ-001 SHALL have parameter TIMEOUT, default 5000000, giving the hold-window length in clk cycles (100 ms at 50 MHz).
REQ-002 SHALL have parameter CMD_MAIS, default 8'h18, as the command code that increments nivel.
REQ-003 SHALL have parameter CMD_MENOS, default 8'h52, as the command code that decrements nivel.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 novo  input  1  one-cycle strobe: comando/comparador hold a freshly decoded frame.
REQ-007 comando  input  8  decoded command byte.
REQ-008 comparador  input  8  decoded inverted-command byte.
REQ-009 codigo  output  8  last accepted command.
REQ-010 valido  output  1  one-cycle pulse on acceptance.
REQ-011 erro  output  1  one-cycle pulse on rejection.
REQ-012 cont_erro  output  4  rejected-frame count, saturating.
REQ-013 nivel  output  4  level adjusted by CMD_MAIS/CMD_MENOS.
REQ-014 repetido  output  1  high while the last accepted code equals the previous accepted code and arrived inside the hold window.
REQ-015 led  output  1  high while the hold window runs.
REQ-016 seg_alto  output  7  active-low segments a..g for codigo[7:4].
REQ-017 seg_baixo  output  7  active-low segments a..g for codigo[3:0].

Function
REQ-018 FSM states SHALL be OCIOSO, CHECA, EXECUTA and REJEITA; the state after reset SHALL be OCIOSO.
REQ-019 In OCIOSO with novo=1, the block SHALL register comando and comparador and go to CHECA.
REQ-020 A novo strobe that arrives in any other state SHALL be ignored and SHALL NOT be queued.
REQ-021 In CHECA, the block SHALL go to EXECUTA if comparador == ~comando (bitwise, all 8 bits), else to REJEITA.
REQ-022 EXECUTA SHALL last one cycle and SHALL: load codigo, pulse valido, update nivel and repetido, reload the hold timer, then return to OCIOSO.
REQ-023 REJEITA SHALL last one cycle and SHALL: pulse erro, increment cont_erro (saturating at 15, no wrap), then return to OCIOSO; codigo, nivel, the timer and repetido SHALL be unchanged.
REQ-024 Latency: for novo sampled at edge N, valido or erro SHALL be high during the cycle after edge N+2, and the updated codigo SHALL be visible at the same time.
REQ-025 nivel SHALL be incremented on an accepted CMD_MAIS, saturating at 15.
REQ-026 nivel SHALL be decremented on an accepted CMD_MENOS, saturating at 0.
REQ-027 Any other accepted code SHALL leave nivel unchanged.
REQ-028 The hold timer SHALL be a down-counter of width ceil(log2(TIMEOUT+1)); EXECUTA SHALL load it with TIMEOUT; otherwise it SHALL decrement by 1 per cycle while non-zero.
REQ-029 led SHALL equal (timer != 0).
REQ-030 repetido SHALL be set in EXECUTA if the new code equals the previous codigo and the timer was non-zero on entry; otherwise it SHALL be cleared in EXECUTA.
REQ-031 repetido SHALL also be cleared when the timer reaches 0.
REQ-032 A re-accepted code while the timer is running SHALL retrigger (reload) the timer.
REQ-033 seg_alto and seg_baixo SHALL be combinational from codigo and SHALL use standard hex glyphs 0-9 and A-F (b, d lowercase), active-low.
REQ-034 valido and erro SHALL never be high in the same cycle.

Reset
REQ-035 reset=1 at a clock edge SHALL set: state OCIOSO, codigo 8'h00, valido 0, erro 0, cont_erro 0, nivel 0, repetido 0, timer 0, led 0.
REQ-036 reset SHALL have priority over novo and over any in-progress frame; a frame captured in CHECA or EXECUTA when reset is asserted SHALL be discarded with no valido or erro pulse.
REQ-037 After reset, seg_alto and seg_baixo SHALL both display "0" (7'b1000000).

Verification
REQ-038 Valid frame: comando=8'h45, comparador=8'hBA, novo pulsed at edge N -> valido=1 for one cycle after edge N+2, codigo=8'h45, seg_alto=7'b0011001 ("4"), seg_baixo=7'b0010010 ("5"), led=1.
REQ-039 Bad frame: comando=8'h45, comparador=8'hBB -> erro pulse, cont_erro 0->1, codigo unchanged; 20 bad frames -> cont_erro=15.
REQ-040 Level saturation: 17 valid CMD_MAIS frames -> nivel=15; then 16 valid CMD_MENOS frames -> nivel=0, and a 17th keeps nivel=0.
REQ-041 Repeat/timeout (TIMEOUT=100): code 8'h45 accepted twice 50 cycles apart -> repetido=1 and led held; no further frames -> led and repetido both 0 exactly 100 cycles after the second valido.
REQ-042 Back-to-back and reset: novo asserted in CHECA -> ignored, only one valido; reset asserted in CHECA -> no valido, all outputs at reset values on the next cycle.
